// File: rtl/fdiv_iter_pkg.sv
// Shared binary32 constants, FSM/result-class encodings and a leading-zero helper
// for the iterative divider.
package fdiv_iter_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int BIAS   = 127;
  localparam int QUO_W  = 26;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_ITER, ST_DONE} state_e;
  typedef enum logic [1:0] {RK_NUM, RK_ZERO, RK_INF, RK_NAN} kind_e;

  function automatic logic [4:0] lzc24(input logic [MANT_W-1:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < MANT_W; i++)
      if (m[i]) n = 5'(MANT_W - 1 - i);
    return n;
  endfunction

endpackage

// File: rtl/fdiv_step.sv
// One radix-2 restoring division step: trial subtract, quotient bit, shifted remainder.
module fdiv_step
  import fdiv_iter_pkg::*;
(
  input  logic [MANT_W:0]   rem,
  input  logic [MANT_W-1:0] dvs,
  output logic              q,
  output logic [MANT_W:0]   rem_nxt
);
  logic [MANT_W+1:0] diff;
  logic [MANT_W:0]   rem_sel;

  assign diff    = {1'b0, rem} - {2'b0, dvs};
  assign q       = ~diff[MANT_W+1];
  assign rem_sel = q ? diff[MANT_W:0] : rem;
  assign rem_nxt = rem_sel << 1;

endmodule

// File: rtl/fdiv_iter.sv
// Iterative binary32 divider, BPC quotient bits per cycle, fixed latency.
// Define FDIV_SPECIAL_EN to enable NaN/infinity handling.
module fdiv_iter
  import fdiv_iter_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        order,
  output logic        accepted,
  output logic        done,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd
);
  localparam int ITER = (QUO_W + BPC - 1) / BPC;
  localparam int QW   = ITER * BPC;
  localparam int XB   = QW - QUO_W;
  localparam int CW   = $clog2(ITER);

  state_e               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [31:0]          opa, opb;
  logic [MANT_W:0]      rem_q;
  logic [MANT_W-1:0]    dvs_q;
  logic [QW-1:0]        quo_q;
  logic signed [10:0]   exp_q;
  logic                 sign_q;
  kind_e                kind_q;

  assign accepted = order & rstn & (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accepted) state_nxt = ST_PREP;
      ST_PREP: state_nxt = ST_ITER;
      ST_ITER: if (cnt == CW'(ITER - 1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand unpack: subnormals get exponent 1 and are shifted up to a leading one.
  logic [MANT_W-1:0]  ma_raw, mb_raw, ma, mb;
  logic [4:0]         sha, shb;
  logic signed [10:0] ea, eb, exp_n;
  logic               a_zero, b_zero;
  kind_e              kind_n;

  always_comb begin
    ma_raw = {|opa[30:23], opa[22:0]};
    mb_raw = {|opb[30:23], opb[22:0]};
    sha    = lzc24(ma_raw);
    shb    = lzc24(mb_raw);
    ma     = ma_raw << sha;
    mb     = mb_raw << shb;
    ea     = $signed({3'b0, opa[30:23] | {7'b0, ~|opa[30:23]}}) - $signed({6'b0, sha});
    eb     = $signed({3'b0, opb[30:23] | {7'b0, ~|opb[30:23]}}) - $signed({6'b0, shb});
    exp_n  = ea - eb + $signed(11'(BIAS));
    a_zero = ~|opa[30:0];
    b_zero = ~|opb[30:0];
  end

`ifdef FDIV_SPECIAL_EN
  logic a_inf, b_inf, a_nan, b_nan;
  always_comb begin
    a_inf  = (&opa[30:23]) & ~|opa[22:0];
    b_inf  = (&opb[30:23]) & ~|opb[22:0];
    a_nan  = (&opa[30:23]) & |opa[22:0];
    b_nan  = (&opb[30:23]) & |opb[22:0];
    kind_n = RK_NUM;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) kind_n = RK_NAN;
    else if (a_inf | b_zero)                                 kind_n = RK_INF;
    else if (b_inf | a_zero)                                 kind_n = RK_ZERO;
  end
`else
  always_comb begin
    kind_n = RK_NUM;
    if (b_zero)      kind_n = RK_INF;
    else if (a_zero) kind_n = RK_ZERO;
  end
`endif

  logic [BPC:0][MANT_W:0] rem_c;
  logic [BPC-1:0]         q_c;

  assign rem_c[0] = rem_q;
  for (genvar i = 0; i < BPC; i++) begin : g_step
    fdiv_step u_step (
      .rem    (rem_c[i]),
      .dvs    (dvs_q),
      .q      (q_c[BPC-1-i]),
      .rem_nxt(rem_c[i+1])
    );
  end

  // Quotient bits past the 26 that matter only feed the sticky bit.
  logic extra;
  if (XB > 0) begin : g_xb
    assign extra = |quo_q[XB-1:0];
  end else begin : g_nxb
    assign extra = 1'b0;
  end

  logic [QUO_W-1:0]   q26;
  logic               norm, grd, stk, rnd;
  logic [MANT_W-1:0]  mant;
  logic [MANT_W:0]    mant_r;
  logic signed [10:0] exp_r;
  logic [31:0]        res;
  logic               unused_ok;

  assign q26       = quo_q[QW-1 -: QUO_W];
  assign unused_ok = mant_r[MANT_W-1];

  always_comb begin
    norm   = q26[QUO_W-1];
    mant   = norm ? q26[QUO_W-1:2] : q26[QUO_W-2:1];
    grd    = norm ? q26[1] : q26[0];
    stk    = (norm & q26[0]) | extra | (|rem_q);
    rnd    = grd & (stk | mant[0]);
    mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, rnd};
    // A rounding carry leaves mant_r = 2^24, whose low 23 bits are already zero.
    exp_r  = exp_q - $signed({10'b0, ~norm}) + $signed({10'b0, mant_r[MANT_W]});
    res    = {sign_q, exp_r[EXP_W-1:0], mant_r[FRAC_W-1:0]};
    if (exp_r < 11'sd1) begin
      res = {sign_q, 31'd0};
    end else if (exp_r > 11'sd254) begin
`ifdef FDIV_SPECIAL_EN
      res = {sign_q, 8'hFF, 23'd0};
`else
      res = {sign_q, 8'hFE, 23'h7FFFFF};
`endif
    end
    case (kind_q)
      RK_ZERO: res = {sign_q, 31'd0};
      RK_INF:  res = {sign_q, 8'hFF, 23'd0};
`ifdef FDIV_SPECIAL_EN
      RK_NAN:  res = QNAN;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      done <= 1'b0;
      rd   <= '0;
      cnt  <= '0;
    end else begin
      done <= (state == ST_DONE);
      if (accepted) begin
        opa <= rs1;
        opb <= rs2;
      end
      if (state == ST_PREP) begin
        rem_q  <= {1'b0, ma};
        dvs_q  <= mb;
        exp_q  <= exp_n;
        sign_q <= opa[31] ^ opb[31];
        kind_q <= kind_n;
        quo_q  <= '0;
        cnt    <= '0;
      end
      if (state == ST_ITER) begin
        rem_q <= rem_c[BPC];
        quo_q <= {quo_q[QW-BPC-1:0], q_c};
        cnt   <= cnt + 1'b1;
      end
      if (state == ST_DONE) rd <= res;
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// Scoreboard bench: three dividers (BPC 1/2/4) share stimulus; per-lane monitors
// compare results and latency against an exact-arithmetic reference model.
module tb_fdiv_iter;

  logic             clk = 1'b0;
  logic             rstn;
  logic             order;
  logic [31:0]      rs1, rs2;
  logic [2:0]       acc, dn;
  logic [2:0][31:0] rdv;
  int               cyc = 0;
  int               tests = 0;
  int               fails = 0;

  typedef struct {
    logic [31:0] rd;
    int          t;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int bpc, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s bpc=%0d got=%h want=%h", nm, bpc, got, want);
    end
  endtask

  function automatic int bpc_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  // Exact quotient via 64-bit integer divide, then round-to-nearest-even.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s, az, bz;
    int ea, eb, e, sh;
    longint unsigned ma, mb, n, r, mant, rest, half;
    s  = a[31] ^ b[31];
    az = (a[30:0] == 31'd0);
    bz = (b[30:0] == 31'd0);
`ifdef FDIV_SPECIAL_EN
    begin
      logic ai, bi, an, bn;
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
      if (ai || bz) return {s, 8'hFF, 23'd0};
      if (bi || az) return {s, 31'd0};
    end
`else
    if (bz) return {s, 8'hFF, 23'd0};
    if (az) return {s, 31'd0};
`endif
    ma = {40'd0, (a[30:23] != 8'd0), a[22:0]};
    mb = {40'd0, (b[30:23] != 8'd0), b[22:0]};
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    while (ma < (64'd1 << 23)) begin ma = ma << 1; ea--; end
    while (mb < (64'd1 << 23)) begin mb = mb << 1; eb--; end
    n = (ma << 30) / mb;
    r = (ma << 30) % mb;
    e = ea - eb + 127;
    if (n >= (64'd1 << 30)) sh = 7;
    else begin sh = 6; e--; end
    mant = n >> sh;
    rest = n & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rest > half || (rest == half && (r != 0 || mant[0]))) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e++; end
    if (e < 1) return {s, 31'd0};
`ifdef FDIV_SPECIAL_EN
    if (e > 254) return {s, 8'hFF, 23'd0};
`else
    if (e > 254) return {s, 8'hFE, 23'h7FFFFF};
`endif
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k < 6)       v[30:23] = 8'($urandom_range(110, 145));
    else if (k == 6) v[30:23] = 8'd0;
    else if (k == 7) v[30:0]  = 31'd0;
    return v;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int B   = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int LAT = (26 + B - 1) / B + 2;
    exp_t        sb[$];
    exp_t        e, ne;
    logic        busy_acc;
    logic [31:0] last_rd;
    int          pend_l = 0;

    fdiv_iter #(.BPC(B)) u_dut (
      .clk     (clk),
      .rstn    (rstn),
      .order   (order),
      .accepted(acc[g]),
      .done    (dn[g]),
      .rs1     (rs1),
      .rs2     (rs2),
      .rd      (rdv[g])
    );

    always @(negedge clk) begin
      if (!rstn) begin
        sb.delete();
        busy_acc = 1'b0;
        last_rd  = '0;
      end else begin
        if (dn[g]) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done bpc=%0d got=%h want=no-done", B, rdv[g]);
          end else begin
            e = sb.pop_front();
            chk("result", B, rdv[g], e.rd);
            chk("latency", B, 32'(cyc - e.t), 32'(LAT));
            chk("busy_accept", B, {31'd0, busy_acc}, 32'd0);
            busy_acc = 1'b0;
          end
          last_rd = rdv[g];
        end else begin
          chk("rd_hold", B, rdv[g], last_rd);
        end
        if (acc[g]) begin
          if (sb.size() != 0) busy_acc = 1'b1;
          ne.rd = ref_div(rs1, rs2);
          ne.t  = cyc + 1;
          sb.push_back(ne);
        end
      end
      pend_l = sb.size();
    end
  end

  function automatic int pending();
    return g_lane[0].pend_l + g_lane[1].pend_l + g_lane[2].pend_l;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (pending() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("FAIL drain_timeout got=%0d pending want=0", pending());
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    drain();
    rs1 = a; rs2 = b; order = 1'b1;
    @(posedge clk); #1;
    order = 1'b0; rs1 = $urandom; rs2 = $urandom;
  endtask

  logic [31:0] dir_a [6] = '{32'h40C00000, 32'h3F800000, 32'h00800000,
                             32'h00000001, 32'h7F000000, 32'h3F800000};
  logic [31:0] dir_b [6] = '{32'h40000000, 32'h40400000, 32'h4B000000,
                             32'h00000001, 32'h3E800000, 32'h00000000};
`ifdef FDIV_SPECIAL_EN
  logic [31:0] dir_q [6] = '{32'h40400000, 32'h3EAAAAAB, 32'h00000000,
                             32'h3F800000, 32'h7F800000, 32'h7F800000};
`else
  logic [31:0] dir_q [6] = '{32'h40400000, 32'h3EAAAAAB, 32'h00000000,
                             32'h3F800000, 32'h7F7FFFFF, 32'h7F800000};
`endif

  initial begin
    rstn = 1'b0; order = 1'b1; rs1 = 32'h3F800000; rs2 = 32'h40000000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_accepted", bpc_of(i), {31'd0, acc[i]}, 32'd0);
      chk("reset_done", bpc_of(i), {31'd0, dn[i]}, 32'd0);
      chk("reset_rd", bpc_of(i), rdv[i], 32'd0);
    end
    @(posedge clk); #1;
    rstn = 1'b1; order = 1'b0;

    for (int k = 0; k < 6; k++) begin
      issue(dir_a[k], dir_b[k]);
      drain();
      for (int i = 0; i < 3; i++) chk("directed", bpc_of(i), rdv[i], dir_q[k]);
    end

    for (int k = 0; k < 60; k++) issue(rnd_op(), rnd_op());
    drain();

    // Order held high with operands changing every cycle.
    order = 1'b1;
    for (int k = 0; k < 50; k++) begin
      rs1 = rnd_op(); rs2 = rnd_op();
      @(posedge clk); #1;
    end
    order = 1'b0;
    drain();

    // Reset for one cycle while all lanes are iterating.
    issue(rnd_op(), rnd_op());
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; order = 1'b1; rs1 = 32'h40C00000; rs2 = 32'h40000000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("accept_after_reset", bpc_of(i), {31'd0, acc[i]}, 32'd1);
    @(posedge clk); #1;
    order = 1'b0; rs1 = $urandom; rs2 = $urandom;
    drain();
    for (int i = 0; i < 3; i++) chk("reset_recover", bpc_of(i), rdv[i], 32'h40400000);
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("FAIL final_pending got=%0d want=0", pending());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
